// File: rtl/mem_hex_dumper.sv
// Drains the receive RAM over the UART TX handshake as uppercase ASCII hex:
// "HH HH ... HH\r\n", reading bytes from address 0 up to the saturated length.
module mem_hex_dumper #(
  parameter int D_WIDTH = 8,
  parameter int A_WIDTH = 4
) (
  input  logic               i_clk,
  input  logic               i_n_rst,
  input  logic               i_start,
  input  logic [A_WIDTH:0]   i_len,
  output logic [A_WIDTH-1:0] o_raddr,
  input  logic [D_WIDTH-1:0] i_rdata,
  output logic               o_tx_start,
  output logic [7:0]         o_tx_data,
  input  logic               i_tx_busy,
  output logic               o_busy,
  output logic               o_done
);

  localparam logic [A_WIDTH:0] DEPTH = {1'b1, {A_WIDTH{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_REQ = 3'd1,
    S_RD_CAP = 3'd2,
    S_TX_REQ = 3'd3,
    S_TX_ACK = 3'd4,
    S_TX_END = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    SEL_HI = 3'd0,
    SEL_LO = 3'd1,
    SEL_SP = 3'd2,
    SEL_CR = 3'd3,
    SEL_LF = 3'd4
  } sel_t;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) begin
      return 8'h30 + {4'd0, n};
    end else begin
      return 8'h37 + {4'd0, n};
    end
  endfunction

  function automatic logic [7:0] char_of(input sel_t sel, input logic [7:0] b);
    case (sel)
      SEL_HI:  return hex_char(b[7:4]);
      SEL_LO:  return hex_char(b[3:0]);
      SEL_SP:  return 8'h20;
      SEL_CR:  return 8'h0D;
      SEL_LF:  return 8'h0A;
      default: return 8'h00;
    endcase
  endfunction

  state_t             r_state, w_state;
  sel_t               r_sel, w_sel;
  logic [A_WIDTH:0]   r_idx, w_idx;
  logic [A_WIDTH:0]   r_cnt, w_cnt;
  logic [7:0]         r_byte, w_byte;
  logic [A_WIDTH-1:0] r_raddr, w_raddr;
  logic               r_tx_start, w_tx_start;
  logic [7:0]         r_tx_data, w_tx_data;
  logic               r_busy, w_busy;
  logic               r_done, w_done;

  logic [A_WIDTH:0]   w_len_sat;
  logic [A_WIDTH:0]   w_idx_inc;
  logic [7:0]         w_char;

  assign w_len_sat = (i_len > DEPTH) ? DEPTH : i_len;
  assign w_idx_inc = r_idx + {{A_WIDTH{1'b0}}, 1'b1};
  assign w_char    = char_of(r_sel, r_byte);

  // State and datapath registers, all cleared asynchronously so a reset withdraws any pending request.
  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      r_state    <= S_IDLE;
      r_sel      <= SEL_HI;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_byte     <= 8'h00;
      r_raddr    <= '0;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_sel      <= w_sel;
      r_idx      <= w_idx;
      r_cnt      <= w_cnt;
      r_byte     <= w_byte;
      r_raddr    <= w_raddr;
      r_tx_start <= w_tx_start;
      r_tx_data  <= w_tx_data;
      r_busy     <= w_busy;
      r_done     <= w_done;
    end
  end

  // Next-state and next-register values; tx_start and done default low so they pulse for one cycle.
  always_comb begin
    w_state    = r_state;
    w_sel      = r_sel;
    w_idx      = r_idx;
    w_cnt      = r_cnt;
    w_byte     = r_byte;
    w_raddr    = r_raddr;
    w_tx_start = 1'b0;
    w_tx_data  = r_tx_data;
    w_busy     = r_busy;
    w_done     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_cnt   = w_len_sat;
          w_idx   = '0;
          w_raddr = '0;
          w_busy  = 1'b1;
          if (w_len_sat == '0) begin
            w_sel   = SEL_CR;
            w_state = S_TX_REQ;
          end else begin
            w_state = S_RD_REQ;
          end
        end else begin
          w_state = S_IDLE;
        end
      end

      S_RD_REQ: begin
        w_raddr = r_idx[A_WIDTH-1:0];
        w_state = S_RD_CAP;
      end

      S_RD_CAP: begin
        w_byte  = i_rdata[7:0];
        w_sel   = SEL_HI;
        w_state = S_TX_REQ;
      end

      S_TX_REQ: begin
        if (!i_tx_busy) begin
          w_tx_start = 1'b1;
          w_tx_data  = w_char;
          w_state    = S_TX_ACK;
        end else begin
          w_state = S_TX_REQ;
        end
      end

      S_TX_ACK: begin
        if (i_tx_busy) begin
          w_state = S_TX_END;
        end else begin
          w_state = S_TX_ACK;
        end
      end

      S_TX_END: begin
        if (!i_tx_busy) begin
          // The last byte of the dump is followed by CR instead of a space.
          case (r_sel)
            SEL_HI: begin
              w_sel   = SEL_LO;
              w_state = S_TX_REQ;
            end
            SEL_LO: begin
              if (w_idx_inc < r_cnt) begin
                w_sel = SEL_SP;
              end else begin
                w_sel = SEL_CR;
              end
              w_state = S_TX_REQ;
            end
            SEL_SP: begin
              w_idx   = w_idx_inc;
              w_raddr = w_idx_inc[A_WIDTH-1:0];
              w_state = S_RD_REQ;
            end
            SEL_CR: begin
              w_sel   = SEL_LF;
              w_state = S_TX_REQ;
            end
            SEL_LF: begin
              w_done  = 1'b1;
              w_busy  = 1'b0;
              w_raddr = '0;
              w_state = S_DONE;
            end
            default: begin
              w_busy  = 1'b0;
              w_state = S_IDLE;
            end
          endcase
        end else begin
          w_state = S_TX_END;
        end
      end

      S_DONE: begin
        w_state = S_IDLE;
      end

      default: begin
        w_busy  = 1'b0;
        w_state = S_IDLE;
      end
    endcase
  end

  assign o_raddr    = r_raddr;
  assign o_tx_start = r_tx_start;
  assign o_tx_data  = r_tx_data;
  assign o_busy     = r_busy;
  assign o_done     = r_done;

endmodule

// File: tb/tb_mem_hex_dumper.sv
// Directed bench for mem_hex_dumper: behavioural RAM and UART TX models,
// hand-computed character streams, handshake and timing checks.
module tb_mem_hex_dumper;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       start = 1'b0;
  logic [4:0] len = 5'd0;
  logic [3:0] raddr;
  logic [7:0] rdata;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       busy;
  logic       done;

  logic [7:0] mem [16];
  logic       model_busy;
  int         busy_cnt;
  logic       hold = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] txq[$];
  logic [7:0] expq[$];
  int done_cnt = 0;
  int max_raddr = 0;
  int cyc = 0;
  int last_txs = -100;

  mem_hex_dumper #(.D_WIDTH(8), .A_WIDTH(4)) dut (
    .i_clk      (clk),
    .i_n_rst    (n_rst),
    .i_start    (start),
    .i_len      (len),
    .o_raddr    (raddr),
    .i_rdata    (rdata),
    .o_tx_start (tx_start),
    .o_tx_data  (tx_data),
    .i_tx_busy  (tx_busy),
    .o_busy     (busy),
    .o_done     (done)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM.
  always @(posedge clk) rdata <= mem[raddr];

  // UART TX: busy rises the cycle after tx_start and stays high for 10 cycles.
  assign tx_busy = model_busy | hold;
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      model_busy <= 1'b0;
      busy_cnt   <= 0;
    end else if (tx_start && !model_busy) begin
      model_busy <= 1'b1;
      busy_cnt   <= 10;
    end else if (model_busy) begin
      if (busy_cnt <= 1) model_busy <= 1'b0;
      busy_cnt <= busy_cnt - 1;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: collect transmitted characters and check handshake rules.
  always @(negedge clk) begin
    if (n_rst) begin
      if (tx_start) begin
        chk("txs_while_busy", {31'd0, tx_busy}, 32'd0);
        chk("txs_gap", {31'd0, (cyc - last_txs) >= 3}, 32'd1);
        last_txs <= cyc;
        txq.push_back(tx_data);
      end
      if (done) done_cnt <= done_cnt + 1;
      if (busy && int'(raddr) > max_raddr) max_raddr <= int'(raddr);
    end
  end

  task automatic pulse_start(input logic [4:0] l);
    @(negedge clk);
    len   = l;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_timeout"}, {31'd0, n < 5000}, 32'd1);
  endtask

  task automatic check_seq(input string tag);
    chk({tag, "_nchar"}, txq.size(), expq.size());
    for (int i = 0; i < expq.size() && i < txq.size(); i++)
      chk($sformatf("%s_c%0d", tag, i), {24'd0, txq[i]}, {24'd0, expq[i]});
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_raddr"}, {28'd0, raddr}, 32'd0);
    chk({tag, "_txs"}, {31'd0, tx_start}, 32'd0);
    chk({tag, "_txd"}, {24'd0, tx_data}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    string hx;
    hx = "0123456789ABCDEF";
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outs("rst");
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    // len=0: only CR LF; a start coinciding with done is ignored
    txq.delete();
    expq = '{8'h0D, 8'h0A};
    base = done_cnt;
    pulse_start(5'd0);
    chk("z_busy", {31'd0, busy}, 32'd1);
    wait_done("z");
    chk("z_busy_at_done", {31'd0, busy}, 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("z_start_in_done", {31'd0, busy}, 32'd0);
    repeat (5) @(negedge clk);
    chk("z_busy_after", {31'd0, busy}, 32'd0);
    chk("z_ndone", done_cnt - base, 32'd1);
    chk("z_max_raddr", max_raddr, 32'd0);
    check_seq("z");

    // len=2, 3A F0, with first-character latency
    mem[0] = 8'h3A; mem[1] = 8'hF0;
    txq.delete();
    expq = '{8'h33, 8'h41, 8'h20, 8'h46, 8'h30, 8'h0D, 8'h0A};
    base = done_cnt;
    pulse_start(5'd2);
    chk("a_busy_e0", {31'd0, busy}, 32'd1);
    chk("a_raddr_e0", {28'd0, raddr}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("a_txs_e2", {31'd0, tx_start}, 32'd0);
    @(negedge clk);
    chk("a_txs_e3", {31'd0, tx_start}, 32'd1);
    chk("a_txd_e3", {24'd0, tx_data}, 32'h33);
    wait_done("a");
    chk("a_busy_at_done", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    chk("a_ndone", done_cnt - base, 32'd1);
    chk("a_max_raddr", max_raddr, 32'd1);
    check_seq("a");

    // Nibble boundary 9/A
    mem[0] = 8'h09; mem[1] = 8'hA0;
    txq.delete();
    expq = '{8'h30, 8'h39, 8'h20, 8'h41, 8'h30, 8'h0D, 8'h0A};
    pulse_start(5'd2);
    wait_done("b");
    repeat (3) @(negedge clk);
    check_seq("b");

    // len=20 saturates to 16
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    txq.delete();
    expq.delete();
    for (int i = 0; i < 16; i++) begin
      expq.push_back(8'(hx.getc(i / 16)));
      expq.push_back(8'(hx.getc(i % 16)));
      if (i != 15) expq.push_back(8'h20);
    end
    expq.push_back(8'h0D);
    expq.push_back(8'h0A);
    base = done_cnt;
    pulse_start(5'd20);
    wait_done("s");
    repeat (3) @(negedge clk);
    chk("s_ndone", done_cnt - base, 32'd1);
    chk("s_max_raddr", max_raddr, 32'd15);
    check_seq("s");

    // tx_busy stall with a dropped second start
    mem[0] = 8'h3A; mem[1] = 8'hF0;
    txq.delete();
    expq = '{8'h33, 8'h41, 8'h20, 8'h46, 8'h30, 8'h0D, 8'h0A};
    base = done_cnt;
    hold = 1'b1;
    pulse_start(5'd2);
    repeat (250) @(negedge clk);
    pulse_start(5'd5);
    repeat (250) @(negedge clk);
    chk("h_nchar_stalled", txq.size(), 32'd0);
    chk("h_busy_stalled", {31'd0, busy}, 32'd1);
    hold = 1'b0;
    wait_done("h");
    repeat (20) @(negedge clk);
    chk("h_ndone", done_cnt - base, 32'd1);
    chk("h_busy_after", {31'd0, busy}, 32'd0);
    check_seq("h");

    // Reset during the third character, then a clean len=1 dump
    txq.delete();
    pulse_start(5'd2);
    n = 0;
    while (txq.size() < 3 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("r_third_char_timeout", {31'd0, n < 2000}, 32'd1);
    @(posedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    check_reset_outs("r_abort");
    @(negedge clk);
    n_rst = 1'b1;
    mem[0] = 8'h5C;
    txq.delete();
    expq = '{8'h35, 8'h43, 8'h0D, 8'h0A};
    pulse_start(5'd1);
    wait_done("r");
    repeat (3) @(negedge clk);
    check_seq("r");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_hex_dumper.md
# mem_hex_dumper

Read-back path for the 16x8 dual-port receive RAM. On a start pulse, reads `len` bytes from address 0 upward through the RAM read port. It sends each byte to the UART transmitter as two uppercase ASCII hex characters, with a space between bytes and CR LF at the end. It sits beside the memory controller: that block fills the RAM from `rx_data`, this block drains it over UART TX. It reuses the existing `tx_start`/`tx_busy` handshake.

## Interface
- `D_WIDTH`, default 8: RAM data width. Fixed at 8 for hex formatting.
- `A_WIDTH`, default 4: RAM address width. Depth is 2^A_WIDTH = 16.
- `clk`, in, 1: system clock. All state updates on the rising edge.
- `n_rst`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: single-cycle dump request. Ignored while `busy`=1.
- `len`, in, A_WIDTH+1: number of bytes to dump. Values above 16 saturate to 16.
- `raddr`, out, A_WIDTH: RAM read address (registered).
- `rdata`, in, D_WIDTH: RAM read data, valid one cycle after `raddr` changes (synchronous read).
- `tx_start`, out, 1: one-cycle request to the UART TX to send `tx_data`.
- `tx_data`, out, 8: character to send. Held stable from the `tx_start` cycle until the handshake completes.
- `tx_busy`, in, 1: UART TX busy. Rises the cycle after `tx_start` and falls when the stop bit ends.
- `busy`, out, 1: dump in progress.
- `done`, out, 1: one-cycle pulse after the final LF completes.

## Operation
- FSM states: IDLE, RD_REQ, RD_CAP, TX_REQ, TX_ACK, TX_END, DONE.
- Character selector `sel` takes the values HI, LO, SP, CR, LF.
- Internal registers: `idx` (A_WIDTH+1 bits), `cnt` (saturated `len`, A_WIDTH+1 bits), `byte_reg` (8 bits).
- **IDLE**: on `start`=1, latch `cnt`=min(`len`,16), set `idx`=0, set `raddr`=0, set `busy`=1.
  - If `cnt`=0, go to TX_REQ with `sel`=CR.
  - Otherwise go to RD_REQ.
- **RD_REQ**: `raddr`=`idx[A_WIDTH-1:0]` is stable while the RAM samples it. Go to RD_CAP.
- **RD_CAP**: `byte_reg`<=`rdata`. Then `sel`=HI and go to TX_REQ.
- **TX_REQ**: if `tx_busy`=0, drive `tx_start`=1 and register `tx_data`=char(`sel`), then go to TX_ACK. If `tx_busy`=1, stay.
- **TX_ACK**: wait for `tx_busy`=1, then go to TX_END.
- **TX_END**: wait for `tx_busy`=0, then advance `sel`:
  - HI -> LO.
  - LO -> SP if `idx`+1 < `cnt`; otherwise -> CR.
  - SP -> increment `idx`, then RD_REQ.
  - CR -> LF.
  - LF -> DONE.
  - Every transition except SP->RD_REQ and LF->DONE returns to TX_REQ.
- **DONE**: `done`=1 for one cycle, `busy`=0, `raddr`=0. Go to IDLE.
- Character encoding:
  - HI = hex(`byte_reg[7:4]`); LO = hex(`byte_reg[3:0]`).
  - hex(n) = 0x30+n for n in 0..9, 0x41+(n-10) for n in 10..15.
  - SP = 0x20, CR = 0x0D, LF = 0x0A.
- Character count per dump is 3·`cnt`+1, or 2 when `cnt`=0.
- `raddr` never exceeds `cnt`-1. There is no wrap past address 15.
- `start` while `busy`=1 is dropped, not queued.
- `start` and `done` in the same cycle: `start` is ignored. A new start is accepted from the following IDLE cycle.
- A `tx_busy` stall of any length holds the FSM in TX_REQ, TX_ACK or TX_END. No timeout.

## Timing
- Reset values: `raddr`=0, `tx_start`=0, `tx_data`=0x00, `busy`=0, `done`=0. FSM in IDLE, `idx`=0, `cnt`=0, `byte_reg`=0x00.
- Asserting `n_rst` mid-dump aborts immediately: all outputs return to reset values, and any pending `tx_start` is withdrawn.
- Cycle numbering from `start` sampled at edge 0:
  - Edge 0: `busy`=1, `raddr`=0.
  - Edge 1: RD_REQ completes; RD_CAP begins.
  - Edge 2: `byte_reg` captured.
  - Edge 3: first `tx_start` pulse, provided `tx_busy`=0.
- Byte-to-byte read overhead: 2 cycles (RD_REQ, RD_CAP) after the SP handshake ends.
- Successive `tx_start` pulses are separated by at least 3 cycles.
- `tx_start` is never asserted while `tx_busy`=1.
- `done` rises on the cycle after `tx_busy` falls for LF. `busy` falls on the same edge.

## Test plan
- `len`=2, RAM[0]=0x3A, RAM[1]=0xF0, TX model busy for 10 cycles per character -> `tx_data` sequence 0x33,0x41,0x20,0x46,0x30,0x0D,0x0A. Exactly 7 `tx_start` pulses. Then one `done` pulse and `busy`=0.
- `len`=0 -> only 0x0D,0x0A are sent. `raddr` stays 0 and `done` pulses once.
- `len`=20, RAM[i]=i -> saturates to 16 bytes, 49 characters, ending "0F\r\n". Max `raddr` observed is 15.
- RAM[0]=0x09, RAM[1]=0xA0, `len`=2 -> 0x30,0x39,0x20,0x41,0x30,0x0D,0x0A, covering the nibble boundaries at 9/A.
- `tx_busy` held high for 500 cycles before the first character; a second `start` is pulsed mid-dump -> no `tx_start` until `tx_busy` falls. The second `start` is ignored: total character count is unchanged and there is only one `done`.
- `n_rst` pulsed low during the 3rd character -> all outputs return to reset values within the reset assertion. A subsequent `start` with `len`=1 and RAM[0]=0x5C sends 0x35,0x43,0x0D,0x0A.
